// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg -- shared definitions for the transmitter arbiter.
//   arb_state_t : FSM encoding (IDLE=0, OWN=1, HOLD=2)
//   N_REQ_DEF   : default number of requesters
//   TIMEOUT_DEF : default stall limit for the optional timeout
//   lane_lsb()  : LSB position of byte lane i in the packed req_data bus
package tx_arb_pkg;

   localparam int N_REQ_DEF   = 4;
   localparam int TIMEOUT_DEF = 1024;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

   function automatic int lane_lsb(input int i);
      return 8 * i;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker -- combinational rotate-priority encoder.
//   req  in  N      request vector
//   ptr  in  PTR_W  index that has highest priority
//   pick out N      one-hot winner: first set req bit at or after ptr (wrapping)
//   any  out 1      at least one request present
module rr_picker
   import tx_arb_pkg::*;
#(
   parameter int N     = N_REQ_DEF,
   parameter int PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     pick,
   output logic             any
);

   logic [2*N-1:0] dbl;
   logic [2*N-1:0] dbl_pick;
   logic [N-1:0]   rot;
   logic [N-1:0]   rot_pick;

   // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
   always_comb begin
      dbl      = {req, req} >> ptr;
      rot      = dbl[N-1:0];
      rot_pick = rot & (-rot);
      dbl_pick = {rot_pick, rot_pick} << ptr;
      pick     = dbl_pick[2*N-1:N];
      any      = |req;
   end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter -- shares one serial_tx byte interface between N_REQ message
// sources. A grant covers a whole message (until the byte flagged last),
// then priority rotates so the previous owner becomes lowest priority.
//
// Ports
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    in  N_REQ    lane i holds a byte
//   req_data     in  8*N_REQ  lane i = bits [8i+7:8i]
//   req_last     in  N_REQ    lane byte ends its message
//   req_ready    out N_REQ    one-cycle pulse: lane byte consumed this cycle
//   gnt          out N_REQ    one-hot owner, zero when idle
//   tx_data      out 8        byte to serial_tx, held between strobes
//   new_tx_data  out 1        one-cycle strobe to serial_tx
//   tx_busy      in  1        serial_tx busy
//
// Build option: define TX_ARB_TIMEOUT_EN to release a grant whose owner
// has dropped req_valid for TIMEOUT_CYCLES consecutive OWN cycles.
module tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int N_REQ          = N_REQ_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   req_ready,
   output logic [N_REQ-1:0]   gnt,
   output logic [7:0]         tx_data,
   output logic               new_tx_data,
   input  logic               tx_busy
);

   localparam int PTR_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   arb_state_t       state, state_nxt;
   logic [N_REQ-1:0] gnt_nxt;
   logic [N_REQ-1:0] pick;
   logic [PTR_W-1:0] ptr, ptr_nxt;
   logic [PTR_W-1:0] g, g_nxt;
   logic [PTR_W-1:0] g_inc;
   logic [PTR_W-1:0] pick_idx;
   logic             any;
   logic             last_q;
   logic             accept;
   logic             own_valid;
   logic             own_last;
   logic             timed_out;
   logic [7:0]       lane_byte;

   rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_picker (
      .req  (req_valid),
      .ptr  (ptr),
      .pick (pick),
      .any  (any)
   );

   // Owner-lane views; gnt is one-hot so AND-OR selects exactly one lane.
   always_comb begin
      pick_idx  = '0;
      lane_byte = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick[i]) pick_idx = PTR_W'(i);
         if (gnt[i])  lane_byte = lane_byte | req_data[lane_lsb(i) +: 8];
      end
   end

   assign own_valid = |(req_valid & gnt);
   assign own_last  = |(req_last & gnt);
   assign g_inc     = (g == PTR_W'(N_REQ - 1)) ? '0 : g + PTR_W'(1);

`ifdef TX_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] stall_cnt;

   // Counts consecutive OWN cycles with the owner's valid low. Leaving OWN
   // (grant from IDLE, accept into HOLD) clears it.
   always_ff @(posedge clk) begin
      if (!rst_n || state != OWN) stall_cnt <= '0;
      else if (!own_valid)        stall_cnt <= stall_cnt + CNT_W'(1);
   end

   assign timed_out = (state == OWN) && !own_valid &&
                      (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timed_out = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      g_nxt     = g;
      ptr_nxt   = ptr;
      req_ready = '0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (any) begin
               gnt_nxt   = pick;
               g_nxt     = pick_idx;
               state_nxt = OWN;
            end
         end
         OWN: begin
            if (own_valid && !tx_busy) begin
               accept    = 1'b1;
               req_ready = gnt;
               state_nxt = HOLD;
            end else if (timed_out) begin
               gnt_nxt   = '0;
               ptr_nxt   = g_inc;
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            // Strobe cycle; also masks serial_tx's one-cycle busy latency.
            if (last_q) begin
               gnt_nxt   = '0;
               ptr_nxt   = g_inc;
               state_nxt = IDLE;
            end else begin
               state_nxt = OWN;
            end
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= '0;
         g       <= '0;
         ptr     <= '0;
         tx_data <= 8'h00;
         last_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         g     <= g_nxt;
         ptr   <= ptr_nxt;
         if (accept) begin
            tx_data <= lane_byte;
            last_q  <= own_last;
         end
      end
   end

   assign new_tx_data = (state == HOLD);

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter -- directed bench for tx_arbiter. Requesters are byte
// queues; a message-level round-robin model predicts the strobe stream,
// and a per-cycle monitor checks the handshake rules against it.
module tb_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req_valid, req_last, req_ready, gnt;
   logic [8*N-1:0] req_data;
   logic [7:0]   lane [N];
   logic [7:0]   tx_data;
   logic         new_tx_data, tx_busy;

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign req_data[8*gi +: 8] = lane[gi];
   end

   tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .gnt         (gnt),
      .tx_data     (tx_data),
      .new_tx_data (new_tx_data),
      .tx_busy     (tx_busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   logic [8:0] mem [N][32];     // {last, byte}
   int         hd [N];
   int         tl [N];
   int         exp_src [$];
   logic [7:0] exp_byte [$];
   int         log_src [64];
   logic [7:0] log_byte [64];
   int         n_log = 0;
   int         ptr_m = 0;
   int         busy_len = 3;
   int         busy_cnt = 0;
   bit         force_busy = 1'b0;
   logic [N-1:0] rdy_s;

   task automatic chk(input bit ok, input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] expv);
      chk(act == expv, name, act, expv);
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (hd[i] < tl[i]) begin
            req_valid[i] = 1'b1;
            lane[i]      = mem[i][hd[i]][7:0];
            req_last[i]  = mem[i][hd[i]][8];
         end else begin
            req_valid[i] = 1'b0;
            lane[i]      = 8'h00;
            req_last[i]  = 1'b0;
         end
      end
      tx_busy = force_busy || (busy_cnt > 0);
   endtask

   // One clock: sample ready before the edge, update requesters and the
   // serial_tx busy model after it, return at the falling edge.
   task automatic step();
      #1;
      rdy_s = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (rdy_s[i] && hd[i] < tl[i]) hd[i]++;
      if (busy_cnt > 0) busy_cnt--;
      if (new_tx_data) busy_cnt = busy_len;
      drive();
      @(negedge clk);
   endtask

   task automatic push(input int i, input logic [7:0] b, input bit last);
      mem[i][tl[i]] = {last, b};
      tl[i]++;
   endtask

   task automatic clear_q();
      for (int i = 0; i < N; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
   endtask

   function automatic bit q_empty();
      bit e = 1'b1;
      for (int i = 0; i < N; i++) if (hd[i] < tl[i]) e = 1'b0;
      return e;
   endfunction

   // Message-level round robin over everything currently queued.
   task automatic plan();
      int h [N];
      for (int i = 0; i < N; i++) h[i] = hd[i];
      for (int m = 0; m < 64; m++) begin
         int w;
         bit done;
         w = -1;
         for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr_m + k) % N;
            if (w < 0 && h[i] < tl[i]) w = i;
         end
         if (w < 0) break;
         done = 1'b0;
         while (!done && h[w] < tl[w]) begin
            exp_src.push_back(w);
            exp_byte.push_back(mem[w][h[w]][7:0]);
            done = mem[w][h[w]][8];
            h[w]++;
         end
         ptr_m = (w + 1) % N;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_q();
      exp_src.delete();
      exp_byte.delete();
      force_busy = 1'b0;
      drive();
      step();
      rst_n = 1'b1;
      ptr_m = 0;
      drive();
   endtask

   task automatic drain(input int budget, output logic [N-1:0] gor);
      bit done;
      done = 1'b0;
      gor  = '0;
      for (int k = 0; k < budget && !done; k++) begin
         step();
         gor  = gor | gnt;
         done = (exp_src.size() == 0) && (gnt == '0) && q_empty() && (busy_cnt == 0);
      end
      chk(done, "drain_timeout", exp_src.size(), 0);
   endtask

   task automatic wait_strobe(input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         step();
         seen = new_tx_data;
      end
      chk(seen, "wait_strobe_timeout", 0, 1);
   endtask

   // Per-cycle compare process.
   initial begin
      bit         prev_rdy;
      bit         prev_rst;
      logic [7:0] prev_tx;
      int         src;
      prev_rdy = 1'b0;
      prev_rst = 1'b0;
      prev_tx  = 8'h00;
      forever begin
         @(negedge clk);
         #2;
         chk($onehot0(gnt), "gnt_onehot", gnt, 0);
         chk((req_ready & ~(gnt & req_valid)) == '0, "ready_owner", req_ready, gnt & req_valid);
         chk(!((|req_ready) && tx_busy), "ready_while_busy", req_ready, 0);
         chk_eq("strobe_after_ready", new_tx_data, prev_rdy && prev_rst);
         chk(tx_data == prev_tx || new_tx_data || !prev_rst, "tx_data_stable", tx_data, prev_tx);
         if (new_tx_data) begin
            chk(exp_src.size() != 0, "strobe_expected", tx_data, 0);
            if (exp_src.size() != 0) begin
               chk_eq("strobe_byte", tx_data, exp_byte[0]);
               chk_eq("strobe_gnt", gnt, 32'd1 << exp_src[0]);
               void'(exp_src.pop_front());
               void'(exp_byte.pop_front());
            end
            src = -1;
            for (int k = 0; k < N; k++) if (gnt[k]) src = k;
            if (n_log < 64) begin
               log_src[n_log]  = src;
               log_byte[n_log] = tx_data;
               n_log++;
            end
         end
         prev_rdy = |req_ready;
         prev_rst = rst_n;
         prev_tx  = tx_data;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [N-1:0] gor;
      int           held;
      int           seen;
      int           order [5];
      logic [7:0]   t1b [3];
      order = '{0, 1, 2, 3, 0};
      t1b   = '{8'h41, 8'h42, 8'h43};

      clear_q();
      drive();
      step();
      step();
      chk_eq("rst_gnt", gnt, 0);
      chk_eq("rst_ready", req_ready, 0);
      chk_eq("rst_strobe", new_tx_data, 0);
      chk_eq("rst_tx_data", tx_data, 8'h00);
      rst_n = 1'b1;
      step();

      // Requester 1: three-byte message, slow transmitter.
      n_log = 0;
      busy_len = 10;
      push(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b0);
      push(1, 8'h43, 1'b1);
      plan();
      drive();
      step();
      chk_eq("t1_gnt_t1", gnt, 4'b0010);
      chk_eq("t1_ready_t1", req_ready, 4'b0010);
      chk_eq("t1_no_strobe_t1", new_tx_data, 0);
      step();
      chk_eq("t1_strobe_t2", new_tx_data, 1);
      chk_eq("t1_byte_t2", tx_data, 8'h41);
      drain(300, gor);
      chk_eq("t1_gnt_only_r1", gor, 4'b0010);
      chk_eq("t1_strobes", n_log, 3);
      for (int k = 0; k < 3; k++) chk_eq("t1_byte_order", log_byte[k], t1b[k]);
      chk_eq("t1_gnt_after", gnt, 0);

      // Requesters 0 and 2 compete; no interleave, ptr ends at 3.
      do_reset();
      n_log = 0;
      busy_len = 2;
      push(0, 8'hA0, 1'b0);
      push(0, 8'hA1, 1'b1);
      push(2, 8'hC0, 1'b0);
      push(2, 8'hC1, 1'b1);
      plan();
      drive();
      drain(200, gor);
      chk_eq("t2_src0", log_src[0], 0);
      chk_eq("t2_src1", log_src[1], 0);
      chk_eq("t2_src2", log_src[2], 2);
      chk_eq("t2_src3", log_src[3], 2);
      chk_eq("t2_byte3", log_byte[3], 8'hC1);
      chk_eq("t2_model_ptr", ptr_m, 3);
      n_log = 0;
      push(1, 8'h11, 1'b1);
      push(3, 8'h33, 1'b1);
      plan();
      drive();
      drain(200, gor);
      chk_eq("t2b_first_src", log_src[0], 3);
      chk_eq("t2b_second_src", log_src[1], 1);

      // All four continuously requesting one-byte messages.
      do_reset();
      n_log = 0;
      for (int i = 0; i < N; i++) begin
         push(i, 8'(8'h80 + i), 1'b1);
         push(i, 8'(8'h90 + i), 1'b1);
      end
      plan();
      drive();
      drain(400, gor);
      for (int k = 0; k < 5; k++) chk_eq("t3_grant_order", log_src[k], order[k]);
      chk_eq("t3_strobes", n_log, 8);

      // tx_busy held while owning valid data.
      n_log = 0;
      force_busy = 1'b1;
      push(2, 8'h5A, 1'b1);
      plan();
      drive();
      step();
      chk_eq("t4_gnt", gnt, 4'b0100);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (req_ready != '0 || new_tx_data) seen++;
      end
      chk_eq("t4_stalled", seen, 0);
      force_busy = 1'b0;
      drive();
      #1;
      chk_eq("t4_ready_at_k", req_ready, 4'b0100);
      chk_eq("t4_no_strobe_at_k", new_tx_data, 0);
      step();
      chk_eq("t4_strobe_k1", new_tx_data, 1);
      chk_eq("t4_byte_k1", tx_data, 8'h5A);
      drain(100, gor);

      // Owner drops valid mid-message while requester 2 waits.
      do_reset();
      n_log = 0;
      busy_len = 2;
      push(1, 8'h51, 1'b0);
      push(2, 8'h52, 1'b1);
      exp_src.push_back(1);
      exp_byte.push_back(8'h51);
`ifdef TX_ARB_TIMEOUT_EN
      exp_src.push_back(2);
      exp_byte.push_back(8'h52);
`endif
      drive();
      wait_strobe(20);
      held = 0;
      for (int k = 0; k < 150; k++) begin
         step();
         if (gnt == 4'b0010) held++;
         else break;
      end
`ifdef TX_ARB_TIMEOUT_EN
      chk_eq("t5_held_cycles", held, TO);
      chk_eq("t5_idle_gap", gnt, 0);
      step();
      chk_eq("t5_next_owner", gnt, 4'b0100);
      drain(100, gor);
`else
      chk_eq("t5_held_cycles", held, 150);
`endif

      // Reset in the middle of a four-byte message.
      do_reset();
      n_log = 0;
      busy_len = 3;
      push(3, 8'h61, 1'b0);
      push(3, 8'h62, 1'b0);
      push(3, 8'h63, 1'b0);
      push(3, 8'h64, 1'b1);
      plan();
      drive();
      wait_strobe(20);
      step();
      step();
      rst_n = 1'b0;
      clear_q();
      exp_src.delete();
      exp_byte.delete();
      drive();
      step();
      chk_eq("t6_rst_gnt", gnt, 0);
      chk_eq("t6_rst_ready", req_ready, 0);
      chk_eq("t6_rst_strobe", new_tx_data, 0);
      chk_eq("t6_rst_tx_data", tx_data, 8'h00);
      rst_n = 1'b1;
      ptr_m = 0;
      drive();
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (new_tx_data) seen++;
      end
      chk_eq("t6_no_strobe_after_rst", seen, 0);
      chk_eq("t6_strobes_total", n_log, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
